alarm_snooze_cont: RTL
======================

ALARM_SNOOZE_CONT -- requirements
Module: alarm_snooze_cont

Interface
REQ-001 SHALL have parameter SNOOZE_SEC, default 300, snooze length in 1 Hz ticks (1..511).
REQ-002 SHALL have parameter RING_TIMEOUT_SEC, default 60, maximum ring length in ticks (1..255).
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (0..7).
REQ-004 SHALL have port CLK  input  1  system clock; one clock only.
REQ-005 SHALL have port RESETN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port TICK_1HZ  input  1  one-cycle pulse per second.
REQ-007 SHALL have port ALARM_ENABLE  input  1  alarm armed (level).
REQ-008 SHALL have port ALARM_MATCH  input  1  one-cycle pulse when current time equals alarm time.
REQ-009 SHALL have port KEY_STOP  input  1  one-cycle debounced stop request.
REQ-010 SHALL have port KEY_SNOOZE  input  1  one-cycle debounced snooze request.
REQ-011 SHALL have port PIEZO_EN  output  1  drive request to the piezo unit.
REQ-012 SHALL have port RINGING  output  1  high in RING state.
REQ-013 SHALL have port SNOOZING  output  1  high in SNOOZE state.
REQ-014 SHALL have port SNOOZE_LEFT  output  9  remaining snooze seconds, 0 outside SNOOZE.
REQ-015 SHALL have port SNOOZE_CNT  output  3  snoozes used in current event.

Function
REQ-016 SHALL implement states IDLE, RING, SNOOZE; all outputs registered.
REQ-017 IDLE: ALARM_MATCH & ALARM_ENABLE SHALL enter RING next cycle, ring counter=0, SNOOZE_CNT=0.
REQ-018 RING: KEY_STOP SHALL go to IDLE next cycle.
REQ-019 RING: KEY_SNOOZE with SNOOZE_CNT<MAX_SNOOZE SHALL enter SNOOZE, SNOOZE_CNT+1, SNOOZE_LEFT=SNOOZE_SEC.
REQ-020 RING: KEY_SNOOZE with SNOOZE_CNT==MAX_SNOOZE SHALL be ignored (stay RING).
REQ-021 RING: ring counter SHALL increment per TICK_1HZ; tick reaching RING_TIMEOUT_SEC SHALL go to IDLE.
REQ-022 SNOOZE: SNOOZE_LEFT SHALL decrement per TICK_1HZ; tick at SNOOZE_LEFT==1 SHALL enter RING with ring counter=0, SNOOZE_LEFT=0.
REQ-023 SNOOZE: KEY_STOP SHALL go to IDLE; KEY_SNOOZE ignored.
REQ-024 KEY_STOP and KEY_SNOOZE in same cycle: STOP SHALL win.
REQ-025 ALARM_MATCH in RING or SNOOZE SHALL be ignored.
REQ-026 ALARM_ENABLE low in any state SHALL force IDLE next cycle, overriding all other inputs.
REQ-027 TICK coincident with a key SHALL be discarded; key action takes priority.
REQ-028 Counters SHALL saturate/never wrap; SNOOZE_CNT SHALL hold its value in IDLE until next event.

Reset
REQ-029 RESETN low SHALL immediately force IDLE, PIEZO_EN=0, RINGING=0, SNOOZING=0, SNOOZE_LEFT=0, SNOOZE_CNT=0, ring counter=0, beep phase=0, including mid-ring or mid-snooze.

Configuration
REQ-030 Macro ALARM_BEEP_PATTERN_EN defined: beep phase SHALL set to 1 on RING entry and toggle per TICK_1HZ in RING; PIEZO_EN = RINGING & phase (1 s on/1 s off).
REQ-031 Macro undefined: PIEZO_EN SHALL equal RINGING (continuous tone); no phase register.

Structure
REQ-032 Shared package alarm_pkg SHALL hold the state encoding, SNOOZE_LEFT/SNOOZE_CNT widths and default parameter constants.
REQ-033 Seconds down-counter SHALL be sub-module snooze_timer (load, tick, zero flag).

Verification (SNOOZE_SEC=5, RING_TIMEOUT_SEC=4, MAX_SNOOZE=2)
REQ-034 Match with enable=1 -> RINGING=1 next cycle; 4 ticks -> IDLE, PIEZO_EN=0.
REQ-035 Ring, KEY_SNOOZE -> SNOOZING=1, SNOOZE_LEFT=5, CNT=1; 5 ticks -> RINGING=1, SNOOZE_LEFT=0.
REQ-036 Two snoozes then third KEY_SNOOZE -> stays RING, CNT=2; KEY_STOP -> IDLE.
REQ-037 KEY_STOP+KEY_SNOOZE same cycle in RING -> IDLE, CNT unchanged; ALARM_ENABLE=0 during SNOOZE -> IDLE, SNOOZE_LEFT=0.
REQ-038 RESETN pulsed mid-SNOOZE (SNOOZE_LEFT=3) -> all outputs 0 asynchronously.
REQ-039 With ALARM_BEEP_PATTERN_EN, RING over 3 ticks -> PIEZO_EN 1,0,1,0 per second; without -> constant 1.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types, widths and default timing constants for the alarm snooze controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

    localparam int SNOOZE_LEFT_W = 9;
    localparam int SNOOZE_CNT_W  = 3;
    localparam int RING_CNT_W    = 8;

    localparam int DEF_SNOOZE_SEC       = 300;
    localparam int DEF_RING_TIMEOUT_SEC = 60;
    localparam int DEF_MAX_SNOOZE       = 3;

endpackage

// File: rtl/snooze_timer.sv
// Seconds down-counter for the snooze period: clear, load, saturating decrement per tick.
module snooze_timer
    import alarm_pkg::*;
#(
    parameter int W = SNOOZE_LEFT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_snooze_cont.sv
// Alarm ring/snooze controller. Define ALARM_BEEP_PATTERN_EN for a 1 s on / 1 s off
// piezo pattern; otherwise the piezo tone is continuous while ringing.
module alarm_snooze_cont
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SEC       = DEF_SNOOZE_SEC,
    parameter int RING_TIMEOUT_SEC = DEF_RING_TIMEOUT_SEC,
    parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     TICK_1HZ,
    input  logic                     ALARM_ENABLE,
    input  logic                     ALARM_MATCH,
    input  logic                     KEY_STOP,
    input  logic                     KEY_SNOOZE,
    output logic                     PIEZO_EN,
    output logic                     RINGING,
    output logic                     SNOOZING,
    output logic [SNOOZE_LEFT_W-1:0] SNOOZE_LEFT,
    output logic [SNOOZE_CNT_W-1:0]  SNOOZE_CNT
);

    localparam logic [SNOOZE_LEFT_W-1:0] SNOOZE_LD  = SNOOZE_LEFT_W'(SNOOZE_SEC);
    localparam logic [SNOOZE_CNT_W-1:0]  MAX_SN     = SNOOZE_CNT_W'(MAX_SNOOZE);
    localparam logic [RING_CNT_W-1:0]    RING_LAST  = RING_CNT_W'(RING_TIMEOUT_SEC - 1);

    state_e                    state_q, state_d;
    logic [RING_CNT_W-1:0]     ring_cnt_q, ring_cnt_d;
    logic [SNOOZE_CNT_W-1:0]   snz_cnt_q, snz_cnt_d;
    logic                      ringing_q, ringing_d;
    logic                      snoozing_q, snoozing_d;
    logic                      piezo_q, piezo_d;
`ifdef ALARM_BEEP_PATTERN_EN
    logic                      phase_q, phase_d;
`endif

    logic                      t_clr, t_load, t_dec, t_zero;
    logic [SNOOZE_LEFT_W-1:0]  snooze_left;

    snooze_timer #(.W(SNOOZE_LEFT_W)) u_timer (
        .clk      (CLK),
        .rst_n    (RESETN),
        .clr      (t_clr),
        .load     (t_load),
        .load_val (SNOOZE_LD),
        .tick     (t_dec),
        .cnt      (snooze_left),
        .zero     (t_zero)
    );

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        t_clr      = 1'b0;
        t_load     = 1'b0;
        t_dec      = 1'b0;
`ifdef ALARM_BEEP_PATTERN_EN
        phase_d    = phase_q;
`endif
        // Disarming beats every other input; ticks are only consumed on key-free cycles.
        if (!ALARM_ENABLE) begin
            state_d    = ST_IDLE;
            ring_cnt_d = '0;
            t_clr      = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ALARM_MATCH) begin
                        state_d    = ST_RING;
                        ring_cnt_d = '0;
                        snz_cnt_d  = '0;
`ifdef ALARM_BEEP_PATTERN_EN
                        phase_d    = 1'b1;
`endif
                    end
                end
                ST_RING: begin
                    if (KEY_STOP) begin
                        state_d    = ST_IDLE;
                        ring_cnt_d = '0;
                    end else if (KEY_SNOOZE) begin
                        if (snz_cnt_q < MAX_SN) begin
                            state_d    = ST_SNOOZE;
                            snz_cnt_d  = snz_cnt_q + 1'b1;
                            ring_cnt_d = '0;
                            t_load     = 1'b1;
                        end
                    end else if (TICK_1HZ) begin
                        if (ring_cnt_q >= RING_LAST) begin
                            state_d    = ST_IDLE;
                            ring_cnt_d = '0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 1'b1;
                        end
`ifdef ALARM_BEEP_PATTERN_EN
                        phase_d = ~phase_q;
`endif
                    end
                end
                ST_SNOOZE: begin
                    if (KEY_STOP) begin
                        state_d = ST_IDLE;
                        t_clr   = 1'b1;
                    end else if (t_zero) begin
                        state_d    = ST_RING;
                        ring_cnt_d = '0;
`ifdef ALARM_BEEP_PATTERN_EN
                        phase_d    = 1'b1;
`endif
                    end else if (!KEY_SNOOZE && TICK_1HZ) begin
                        t_dec = 1'b1;
                        if (snooze_left == SNOOZE_LEFT_W'(1)) begin
                            state_d    = ST_RING;
                            ring_cnt_d = '0;
`ifdef ALARM_BEEP_PATTERN_EN
                            phase_d    = 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    ring_cnt_d = '0;
                    t_clr      = 1'b1;
                end
            endcase
        end

        ringing_d  = (state_d == ST_RING);
        snoozing_d = (state_d == ST_SNOOZE);
`ifdef ALARM_BEEP_PATTERN_EN
        piezo_d    = ringing_d & phase_d;
`else
        piezo_d    = ringing_d;
`endif
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            piezo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
            piezo_q    <= piezo_d;
        end
    end

`ifdef ALARM_BEEP_PATTERN_EN
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) phase_q <= 1'b0;
        else         phase_q <= phase_d;
    end
`endif

    assign PIEZO_EN    = piezo_q;
    assign RINGING     = ringing_q;
    assign SNOOZING    = snoozing_q;
    assign SNOOZE_LEFT = snooze_left;
    assign SNOOZE_CNT  = snz_cnt_q;

endmodule
